// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory subsystem: MMIO address map,
// RAM region selector and STATUS register field layout.
package dmem_pkg;

   // MMIO register word addresses
   localparam logic [31:0] ADDR_GPIO   = 32'h1000_0000;
   localparam logic [31:0] ADDR_TXDATA = 32'h1000_0004;
   localparam logic [31:0] ADDR_STATUS = 32'h1000_0008;
   localparam logic [31:0] ADDR_CYCLE  = 32'h1000_000C;

   // addr[31:28] value that selects the RAM
   localparam logic [3:0] RAM_REGION = 4'h0;

   // STATUS register layout
   localparam int unsigned STAT_FULL   = 0;
   localparam int unsigned STAT_EMPTY  = 1;
   localparam int unsigned STAT_OVF    = 2;
   localparam int unsigned STAT_CNT_LO = 8;
   localparam int unsigned STAT_CNT_HI = 15;
   localparam int unsigned STAT_CNT_W  = STAT_CNT_HI - STAT_CNT_LO + 1;

   // Byte address to word address (low two bits cleared)
   function automatic logic [31:0] word_addr(input logic [31:0] a);
      return {a[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/dmem_subsystem_tx_fifo.sv
// Synchronous byte FIFO feeding the TX drain port.
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   push_i, push_data_i write request and byte; ignored when full unless a pop
//                       happens in the same cycle
//   full_o              FIFO holds DEPTH entries
//   pop_i               read request; ignored when empty
//   pop_data_o          head byte (0 while empty)
//   empty_o             FIFO holds no entries
//   count_o             number of entries held
module tx_fifo
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH = 8
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       push_i,
   input  logic [7:0]                 push_data_i,
   output logic                       full_o,
   input  logic                       pop_i,
   output logic [7:0]                 pop_data_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [7:0]    mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          do_push;
   logic          do_pop;

   assign full_o  = (count == CW'(DEPTH));
   assign empty_o = (count == '0);
   assign count_o = count;

   // A pop frees the slot the simultaneous push reuses, so full+pop accepts
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   // Head is gated so the output reads 0 after reset rather than stale storage
   assign pop_data_o = empty_o ? 8'h00 : mem[rd_ptr];

   // Storage array, not reset
   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data_i;
      end
   end

   // Pointers and occupancy
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/dmem_subsystem.sv
// Data-memory subsystem on the core data port: word RAM plus MMIO block
// (GPIO, TX byte FIFO, STATUS, free-running CYCLE counter).
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   dmem_addr_i         byte address (bits [1:0] ignored)
//   dmem_wr_data_i      store data
//   dmem_write_i        store strobe
//   dmem_read_i         load strobe
//   dmem_rd_data_o      registered load data, valid the cycle after the load
//   gpio_o              GPIO register
//   tx_data_o           FIFO head byte
//   tx_valid_o          FIFO non-empty
//   tx_ready_i          consumer accepts head byte
module dmem_subsystem
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned FIFO_DEPTH  = 8,
   parameter int unsigned GPIO_W      = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [31:0]       dmem_addr_i,
   input  logic [31:0]       dmem_wr_data_i,
   input  logic              dmem_write_i,
   input  logic              dmem_read_i,
   output logic [31:0]       dmem_rd_data_o,
   output logic [GPIO_W-1:0] gpio_o,
   output logic [7:0]        tx_data_o,
   output logic              tx_valid_o,
   input  logic              tx_ready_i
);

   localparam int unsigned AW = $clog2(DEPTH_WORDS);
   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

   logic [31:0]       ram [DEPTH_WORDS];
   logic [AW-1:0]     ram_idx;
   logic [31:0]       waddr;
   logic              ram_sel;
   logic              wr_ram;
   logic              wr_gpio;
   logic              wr_status;
   logic              wr_cycle;
   logic              fifo_push;
   logic              fifo_pop;
   logic              fifo_full;
   logic              fifo_empty;
   logic [CW-1:0]     fifo_count;
   logic [GPIO_W-1:0] gpio_q;
   logic              ovf_q;
   logic [31:0]       cycle_q;
   logic [31:0]       status_word;
   logic [31:0]       rd_mux;

   // Address decode; upper RAM-region bits alias onto the indexed words
   assign waddr     = word_addr(dmem_addr_i);
   assign ram_sel   = (dmem_addr_i[31:28] == RAM_REGION);
   assign ram_idx   = dmem_addr_i[AW+1:2];
   assign wr_ram    = dmem_write_i && ram_sel;
   assign wr_gpio   = dmem_write_i && (waddr == ADDR_GPIO);
   assign fifo_push = dmem_write_i && (waddr == ADDR_TXDATA);
   assign wr_status = dmem_write_i && (waddr == ADDR_STATUS);
   assign wr_cycle  = dmem_write_i && (waddr == ADDR_CYCLE);

   assign tx_valid_o = !fifo_empty;
   assign fifo_pop   = tx_valid_o && tx_ready_i;
   assign gpio_o     = gpio_q;

   tx_fifo #(
      .DEPTH(FIFO_DEPTH)
   ) u_tx_fifo (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .push_i      (fifo_push),
      .push_data_i (dmem_wr_data_i[7:0]),
      .full_o      (fifo_full),
      .pop_i       (fifo_pop),
      .pop_data_o  (tx_data_o),
      .empty_o     (fifo_empty),
      .count_o     (fifo_count)
   );

   // RAM array, not reset; full-word stores
   always_ff @(posedge clk_i) begin
      if (wr_ram) begin
         ram[ram_idx] <= dmem_wr_data_i;
      end
   end

   // STATUS view of FIFO state before any same-cycle push/pop
   always_comb begin
      status_word = '0;
      status_word[STAT_FULL]  = fifo_full;
      status_word[STAT_EMPTY] = fifo_empty;
      status_word[STAT_OVF]   = ovf_q;
      status_word[STAT_CNT_HI:STAT_CNT_LO] = STAT_CNT_W'(fifo_count);
   end

   // Load source select; RAM read is pre-write because the write lands at the edge
   always_comb begin
      rd_mux = '0;
      if (ram_sel) begin
         rd_mux = ram[ram_idx];
      end else begin
         case (waddr)
            ADDR_GPIO:   rd_mux = 32'(gpio_q);
            ADDR_STATUS: rd_mux = status_word;
            ADDR_CYCLE:  rd_mux = cycle_q;
            default:     rd_mux = '0;
         endcase
      end
   end

   // Load data register, GPIO, sticky overflow and cycle counter
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         dmem_rd_data_o <= '0;
         gpio_q         <= '0;
         ovf_q          <= 1'b0;
         cycle_q        <= '0;
      end else begin
         if (dmem_read_i) dmem_rd_data_o <= rd_mux;
         if (wr_gpio)     gpio_q <= dmem_wr_data_i[GPIO_W-1:0];
         // A drop in the same cycle as a clear leaves overflow set
         if (fifo_push && fifo_full && !fifo_pop) begin
            ovf_q <= 1'b1;
         end else if (wr_status && dmem_wr_data_i[STAT_OVF]) begin
            ovf_q <= 1'b0;
         end
         cycle_q <= wr_cycle ? 32'h0 : cycle_q + 32'h1;
      end
   end

endmodule
